// File: rtl/uart_pkg.sv
// Shared UART types and helpers used by the receiver and transmitter.
// states_t is common to both directions so debug tooling decodes either FSM the same way.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } states_t;

    // Clocks per bit period (integer divide).
    function automatic int unsigned timerlim(input int unsigned clkfreq,
                                             input int unsigned baudrate);
        return clkfreq / baudrate;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// The reset value is a parameter so idle-high lines come out of reset already idle.
module uart_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) ff <= {STAGES{RST_VAL}};
        else         ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, 1 or 2 stop bits, no parity.
// Start edge found on the synchronised line; every bit is then sampled once at its middle.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned c_clkfreq  = 100_000_000,
    parameter int unsigned c_baudrate = 10_000_000,
    parameter int unsigned c_stopbit  = 2
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       rx_i,
    output logic [7:0] rx_dout_o,
    output logic       rx_done_tick_o,
    output logic       rx_frame_err_o,
    output logic       rx_active_o
);

    localparam int unsigned c_timerlim = timerlim(c_clkfreq, c_baudrate);
    localparam logic [31:0] TLIM_M1    = 32'(c_timerlim - 1);
    localparam logic [31:0] HALF_M1    = 32'(c_timerlim / 2 - 1);
    localparam logic [2:0]  STOP_LAST  = 3'(c_stopbit - 1);

    logic        rx_s, rx_q;
    states_t     state, state_nx;
    logic [31:0] timer, timer_nx;
    logic [2:0]  bitcntr, bitcntr_nx;
    logic [7:0]  shreg, shreg_nx;
    logic        err_flag, err_nx;
    logic [7:0]  dout_nx;
    logic        done_nx, ferr_nx;

    uart_sync #(.STAGES(2), .RST_VAL(1'b1)) u_sync (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .d      (rx_i),
        .q      (rx_s)
    );

    always_comb begin
        state_nx   = state;
        timer_nx   = timer + 32'd1;
        bitcntr_nx = bitcntr;
        shreg_nx   = shreg;
        err_nx     = err_flag;
        dout_nx    = rx_dout_o;
        done_nx    = 1'b0;
        ferr_nx    = 1'b0;
        case (state)
            S_IDLE: begin
                timer_nx = '0;
                err_nx   = 1'b0;
                // Needs a real high->low edge, so a held-low line (break) never re-arms.
                if (rx_q && !rx_s) state_nx = S_START;
            end
            S_START: begin
                if (timer == HALF_M1) begin
                    timer_nx = '0;
                    state_nx = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (timer == TLIM_M1) begin
                    timer_nx   = '0;
                    shreg_nx   = {rx_s, shreg[7:1]};
                    bitcntr_nx = bitcntr + 3'd1;
                    if (bitcntr == 3'd7) state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (timer == TLIM_M1) begin
                    timer_nx = '0;
                    if (bitcntr == STOP_LAST) begin
                        // Leaving at mid stop bit gives half a bit to catch a back-to-back start.
                        bitcntr_nx = '0;
                        state_nx   = S_IDLE;
                        dout_nx    = shreg;
                        done_nx    = rx_s & ~err_flag;
                        ferr_nx    = ~rx_s | err_flag;
                        err_nx     = 1'b0;
                    end else begin
                        bitcntr_nx = bitcntr + 3'd1;
                        err_nx     = err_flag | ~rx_s;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
                timer_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_q           <= 1'b1;
            state          <= S_IDLE;
            timer          <= '0;
            bitcntr        <= '0;
            shreg          <= '0;
            err_flag       <= 1'b0;
            rx_dout_o      <= 8'h00;
            rx_done_tick_o <= 1'b0;
            rx_frame_err_o <= 1'b0;
        end else begin
            rx_q           <= rx_s;
            state          <= state_nx;
            timer          <= timer_nx;
            bitcntr        <= bitcntr_nx;
            shreg          <= shreg_nx;
            err_flag       <= err_nx;
            rx_dout_o      <= dout_nx;
            rx_done_tick_o <= done_nx;
            rx_frame_err_o <= ferr_nx;
        end
    end

    assign rx_active_o = (state != S_IDLE);

endmodule
